// File: rtl/dtw_result_packer_if.sv
// dtw_result_packer_if: result capture inputs, AXI-Stream output and status of the DTW result packer
interface dtw_result_packer_if #(
    parameter int WIDTH          = 16,
    parameter int AXIS_WIDTH     = 32,
    parameter int FIFO_PTR_WIDTH = 3
);
    logic                    results_val;
    logic [31:0]             curr_qeu_id;
    logic [31:0]             curr_ref_id;
    logic [WIDTH-1:0]        curr_minval;
    logic [31:0]             curr_position;
    logic [AXIS_WIDTH-1:0]   m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic                    overflow;
    logic [15:0]             drop_count;
    logic [31:0]             result_count;
    logic [FIFO_PTR_WIDTH:0] pending;

    modport master (
        input  results_val, curr_qeu_id, curr_ref_id, curr_minval, curr_position, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, drop_count, result_count, pending
    );

    modport slave (
        output results_val, curr_qeu_id, curr_ref_id, curr_minval, curr_position, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, drop_count, result_count, pending
    );
endinterface

// File: rtl/dtw_result_packer.sv
// dtw_result_packer: buffers DTW match results in a FIFO and streams each as a 4-beat AXI-Stream packet
module dtw_result_packer #(
    parameter int WIDTH          = 16,
    parameter int AXIS_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_PTR_WIDTH = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    dtw_result_packer_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_QID, S_RID, S_MIN, S_POS} state_t;
    localparam logic [FIFO_PTR_WIDTH:0] L_DEPTH = FIFO_DEPTH[FIFO_PTR_WIDTH:0];
    state_t                    r_state;
    state_t                    w_next;
    logic [127:0]              r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_PTR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_PTR_WIDTH:0]   r_count;
    logic [127:0]              r_hold;
    logic                      r_overflow;
    logic [15:0]               r_drop_count;
    logic [31:0]               r_result_count;
    logic [AXIS_WIDTH-1:0]     w_tdata;
    logic [127:0]              w_entry;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fire;

    assign w_entry = {bus.curr_qeu_id, bus.curr_ref_id, 32'(bus.curr_minval), bus.curr_position};
    assign w_full  = r_count == L_DEPTH;
    assign w_push  = bus.results_val && !w_full;
    assign w_pop   = r_state == S_IDLE && r_count != '0;
    assign w_fire  = bus.m_axis_tvalid && bus.m_axis_tready;

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    // FIFO pointers and occupancy; full test uses the registered count so a same-cycle pop frees nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + FIFO_PTR_WIDTH'(w_push);
            r_rd_ptr <= r_rd_ptr + FIFO_PTR_WIDTH'(w_pop);
            r_count  <= r_count + (FIFO_PTR_WIDTH+1)'(w_push) - (FIFO_PTR_WIDTH+1)'(w_pop);
        end
    end

    // Output state and holding register loaded from the FIFO head when a packet starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_hold <= r_mem[r_rd_ptr];
        end
    end

    // Next state: leave idle when data is buffered, otherwise advance one beat per handshake
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) w_next = w_pop ? S_QID : S_IDLE;
        else if (w_fire)       w_next = r_state == S_POS ? S_IDLE : state_t'(r_state + 3'd1);
    end

    // Beat data selected from the holding register; zero while idle
    always_comb begin
        w_tdata = '0;
        case (r_state)
            S_QID:   w_tdata = r_hold[127:96];
            S_RID:   w_tdata = r_hold[95:64];
            S_MIN:   w_tdata = r_hold[63:32];
            S_POS:   w_tdata = r_hold[31:0];
            default: w_tdata = '0;
        endcase
    end

    // Drop accounting (sticky/saturating) and completed-packet count (wrapping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow     <= 1'b0;
            r_drop_count   <= '0;
            r_result_count <= '0;
        end else begin
            if (bus.results_val && w_full) begin
                r_overflow   <= 1'b1;
                r_drop_count <= r_drop_count == 16'hFFFF ? r_drop_count : r_drop_count + 16'd1;
            end
            if (w_fire && r_state == S_POS) r_result_count <= r_result_count + 32'd1;
        end
    end

    assign bus.m_axis_tdata  = w_tdata;
    assign bus.m_axis_tvalid = r_state != S_IDLE;
    assign bus.m_axis_tlast  = r_state == S_POS;
    assign bus.overflow      = r_overflow;
    assign bus.drop_count    = r_drop_count;
    assign bus.result_count  = r_result_count;
    assign bus.pending       = r_count;
endmodule

// File: tb/tb_dtw_result_packer.sv
// tb_dtw_result_packer: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_dtw_result_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    dtw_result_packer_if bus_if();
    dtw_result_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] q, input logic [31:0] r, input logic [15:0] m,
                          input logic [31:0] p, input bit expect_out);
        bus_if.results_val   = 1'b1;
        bus_if.curr_qeu_id   = q;
        bus_if.curr_ref_id   = r;
        bus_if.curr_minval   = m;
        bus_if.curr_position = p;
        if (expect_out) begin
            exp_q.push_back({1'b0, q});
            exp_q.push_back({1'b0, r});
            exp_q.push_back({1'b0, 16'h0, m});
            exp_q.push_back({1'b1, p});
        end
        step();
        bus_if.results_val = 1'b0;
    endtask

    task automatic strobe_id(input int id, input bit expect_out);
        strobe(32'(id), 32'(id) + 32'h100, 16'(id * 3 + 7), 32'(id) + 32'h1000, expect_out);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!bus_if.m_axis_tvalid && bus_if.pending == 0 && exp_q.size() == 0) return;
            step();
        end
        chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted beat must match the head of the expected-beat queue
    always @(negedge clk) begin
        if (rst_n && bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", {31'd0, bus_if.m_axis_tlast, bus_if.m_axis_tdata}, 64'hDEAD);
            else chk("beat", {31'd0, bus_if.m_axis_tlast, bus_if.m_axis_tdata}, {31'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.results_val   = 1'b0;
        bus_if.curr_qeu_id   = '0;
        bus_if.curr_ref_id   = '0;
        bus_if.curr_minval   = '0;
        bus_if.curr_position = '0;
        bus_if.m_axis_tready = 1'b1;
        step();
        step();
        chk("rst_tvalid", 64'(bus_if.m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(bus_if.m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(bus_if.m_axis_tlast), 64'd0);
        chk("rst_overflow", 64'(bus_if.overflow), 64'd0);
        chk("rst_drop", 64'(bus_if.drop_count), 64'd0);
        chk("rst_result", 64'(bus_if.result_count), 64'd0);
        chk("rst_pending", 64'(bus_if.pending), 64'd0);
        rst_n = 1'b1;
        step();

        // single result with exact latency
        strobe(32'h11, 32'h22, 16'h1234, 32'h5678, 1'b1);
        chk("lat_pending_n1", 64'(bus_if.pending), 64'd1);
        chk("lat_tvalid_n1", 64'(bus_if.m_axis_tvalid), 64'd0);
        step();
        chk("lat_beat0", {31'd0, bus_if.m_axis_tvalid, bus_if.m_axis_tdata}, {31'd1, 32'h11});
        chk("lat_pending_n2", 64'(bus_if.pending), 64'd0);
        step();
        step();
        step();
        chk("lat_beat3", {31'd0, bus_if.m_axis_tlast, bus_if.m_axis_tdata}, {31'd1, 32'h5678});
        step();
        chk("lat_result", 64'(bus_if.result_count), 64'd1);
        chk("lat_idle", 64'(bus_if.m_axis_tvalid), 64'd0);
        wait_idle("single");

        // back-pressure during beat 1
        strobe(32'h11, 32'h22, 16'h1234, 32'h5678, 1'b1);
        step();
        step();
        bus_if.m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {31'd0, bus_if.m_axis_tvalid, bus_if.m_axis_tdata}, {31'd1, 32'h22});
            step();
        end
        bus_if.m_axis_tready = 1'b1;
        wait_idle("backpressure");
        chk("bp_result", 64'(bus_if.result_count), 64'd2);

        // overflow: 10 back-to-back strobes with sink stalled
        bus_if.m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) strobe_id(i, i < 9);
        chk("ovf_pending", 64'(bus_if.pending), 64'd8);
        chk("ovf_flag", 64'(bus_if.overflow), 64'd1);
        chk("ovf_drops", 64'(bus_if.drop_count), 64'd1);
        bus_if.m_axis_tready = 1'b1;
        wait_idle("overflow");
        chk("ovf_result", 64'(bus_if.result_count), 64'd11);
        chk("ovf_sticky", 64'(bus_if.overflow), 64'd1);

        // simultaneous push and pop with three entries buffered
        bus_if.m_axis_tready = 1'b0;
        for (int i = 20; i < 24; i++) strobe_id(i, 1'b1);
        chk("sim_pending_pre", 64'(bus_if.pending), 64'd3);
        bus_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 20 && bus_if.m_axis_tvalid; i++) step();
        chk("sim_idle_seen", 64'(bus_if.m_axis_tvalid), 64'd0);
        chk("sim_pending_idle", 64'(bus_if.pending), 64'd3);
        strobe_id(24, 1'b1);
        chk("sim_pending_post", 64'(bus_if.pending), 64'd3);
        wait_idle("simultaneous");
        chk("sim_result", 64'(bus_if.result_count), 64'd16);

        // reset asserted during beat 2
        strobe(32'hAA, 32'hBB, 16'hCCDD, 32'hEE, 1'b1);
        step();
        step();
        step();
        chk("mid_beat2", 64'(bus_if.m_axis_tdata), 64'h0000CCDD);
        rst_n = 1'b0;
        #1;
        chk("mid_tvalid", 64'(bus_if.m_axis_tvalid), 64'd0);
        chk("mid_tlast", 64'(bus_if.m_axis_tlast), 64'd0);
        chk("mid_tdata", 64'(bus_if.m_axis_tdata), 64'd0);
        chk("mid_counts", {bus_if.drop_count, bus_if.result_count, 11'd0, bus_if.overflow, bus_if.pending}, 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        strobe(32'h31, 32'h32, 16'h0033, 32'h34, 1'b1);
        wait_idle("post_reset");
        chk("post_reset_result", 64'(bus_if.result_count), 64'd1);

        // drop saturation and result wrap from preset counter values
        bus_if.m_axis_tready = 1'b0;
        force dut.r_drop_count = 16'hFFFE;
        step();
        release dut.r_drop_count;
        for (int i = 40; i < 52; i++) strobe_id(i, i < 49);
        chk("sat_drops", 64'(bus_if.drop_count), 64'hFFFF);
        chk("sat_pending", 64'(bus_if.pending), 64'd8);
        force dut.r_result_count = 32'hFFFF_FFFF;
        step();
        release dut.r_result_count;
        step();
        chk("wrap_preset", 64'(bus_if.result_count), 64'hFFFF_FFFF);
        bus_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 50 && bus_if.result_count == 32'hFFFF_FFFF; i++) step();
        chk("wrap_zero", 64'(bus_if.result_count), 64'd0);
        wait_idle("wrap");
        chk("wrap_final", 64'(bus_if.result_count), 64'd8);
        chk("sat_hold", 64'(bus_if.drop_count), 64'hFFFF);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtw_result_packer.md
# dtw_result_packer

Serializer on the result side of the subsequence DTW core: captures each completed query/reference match (query id, reference id, minimum distance, best-match position) on the single-cycle `results_val` strobe, buffers it in a small FIFO, and streams it out as a fixed 4-beat AXI-Stream packet toward the host DMA. It decouples the DTW core, which never stalls on its result output, from a back-pressuring stream sink, and reports drops when the buffer overflows.

## Interface
- `WIDTH`, 16: width of `curr_minval`; must be ≤ 32.
- `AXIS_WIDTH`, 32: stream data width; fixed at 32, and other values are unsupported.
- `FIFO_DEPTH`, 8: result entries buffered; must be a power of 2.
- `FIFO_PTR_WIDTH`, 3: log2(`FIFO_DEPTH`).

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous active-low reset. Deassertion is synchronized to `clk` outside this block.
- `results_val` in 1: one-cycle strobe; the four result fields below are valid in this cycle.
- `curr_qeu_id` in 32: query id.
- `curr_ref_id` in 32: reference id.
- `curr_minval` in WIDTH: minimum DTW distance.
- `curr_position` in 32: best-match reference position.
- `m_axis_tdata` out AXIS_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: high on beat 3 of each packet.
- `overflow` out 1: sticky; set when a result is dropped.
- `drop_count` out 16: dropped results; saturates at 16'hFFFF.
- `result_count` out 32: packets fully sent; wraps at 2^32.
- `pending` out FIFO_PTR_WIDTH+1: current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- FIFO entry: {qeu_id, ref_id, minval zero-extended to 32, position}, 128 bits.
- Push occurs when `results_val` is high and `pending < FIFO_DEPTH`.
  - The full test uses the registered occupancy. A pop in the same cycle does not free space for that push.
- If `results_val` is high while `pending == FIFO_DEPTH`:
  - the entry is dropped;
  - `overflow` is set to 1;
  - `drop_count` increments, saturating.
- Output FSM states: S_IDLE, S_QID, S_RID, S_MIN, S_POS.
- S_IDLE, FIFO non-empty:
  - latch the head entry into the output holding registers;
  - pop the FIFO;
  - go to S_QID.
- S_IDLE, FIFO empty: stay in S_IDLE.
- Beats and `m_axis_tdata` per state:
  - S_QID (beat 0): qeu_id.
  - S_RID (beat 1): ref_id.
  - S_MIN (beat 2): {{(32-WIDTH){1'b0}}, minval}.
  - S_POS (beat 3): position, with `m_axis_tlast` = 1.
- `m_axis_tvalid` = 1 in S_QID..S_POS and 0 in S_IDLE.
- Each state advances to the next only on `m_axis_tvalid & m_axis_tready`.
- After the S_POS handshake:
  - `result_count` increments;
  - the FSM returns to S_IDLE.
- While `tvalid & !tready`, `tdata` and `tlast` are held stable. `tvalid` never drops until the handshake.
- Simultaneous push and pop in the same cycle: `pending` is unchanged, and both operations complete.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are derived from `pending`.
- `overflow` and `drop_count` clear only on reset.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0;
  - `overflow` = 0, `drop_count` = 0, `result_count` = 0, `pending` = 0;
  - FSM = S_IDLE, FIFO empty.
- Reset asserted mid-packet: the packet is abandoned and the FIFO contents are discarded. There is no partial resume.
- Latency, empty FIFO, `m_axis_tready` held 1:
  - `results_val` in cycle N;
  - `pending` = 1 in cycle N+1;
  - beat 0 valid in cycle N+2;
  - beat 3 (tlast) in cycle N+5;
  - `result_count` updated in cycle N+6.
- Packet throughput: 5 cycles per packet with `tready` = 1, i.e. 4 beats plus one S_IDLE bubble.
- A result pushed in cycle N is visible in `pending` at N+1. A pop at the S_IDLE→S_QID edge is visible one cycle later.

## Test plan
- Single result: qeu_id=0x11, ref_id=0x22, minval=0x1234, position=0x5678, `tready`=1.
  - Required: beats 0x11, 0x22, 0x00001234, 0x5678 in cycles N+2..N+5.
  - `tlast` only on 0x5678; `result_count`=1; `pending` back to 0.
- Back-pressure: same result, `tready` low for 3 cycles during beat 1.
  - Required: `tdata`=0x22 and `tvalid`=1 held for all 3 cycles.
  - Packet completes intact; no beat duplicated or skipped.
- Overflow: `tready`=0, 10 strobes with qeu_id 0..9, FIFO_DEPTH=8.
  - Required: `pending` caps at 8; `overflow`=1; `drop_count`=1.
  - Head id 0 is latched into the output registers and frees one slot, so 9 entries are accepted in total.
  - After `tready`=1, packets for ids 0..8 emerge in order; `result_count`=9.
- Simultaneous push/pop: FIFO holding 3 entries; strobe in the same cycle as the S_IDLE→S_QID pop.
  - Required: `pending` stays 3; output order is preserved.
- Reset mid-packet: `rst_n` low during beat 2.
  - Required: `tvalid`, `tlast`, `tdata` go to 0 immediately; all counters are 0.
  - After release, a new strobe yields a clean packet starting with beat 0.
- Saturation/wrap: force 70000 drops and run `result_count` from 0xFFFFFFFF.
  - Required: `drop_count`=0xFFFF; `result_count` wraps to 0.
